// File: rtl/matrix_feeder.sv
// Host-to-core sequencer: streams matrices A then B into the multiply core and forwards its results.
// Optional DIM_CHECK_EN rejects jobs whose inner dimensions disagree before any data is loaded.
module matrix_feeder (
   input  logic               clk,
   input  logic               rst,
   // host side
   input  logic               start,
   input  logic [1:0]         a_rows,
   input  logic [1:0]         a_cols,
   input  logic [1:0]         b_rows,
   input  logic [1:0]         b_cols,
   input  logic signed [7:0]  host_data,
   input  logic               host_valid,
   output logic               host_ready,
   // core drive
   output logic [7:0]         in_data,
   output logic               next_matrix,
   output logic               can_read,
   output logic               can_cao,
   output logic [1:0]         row_counter,
   output logic [1:0]         col_counter,
   // core return
   input  logic signed [19:0] core_out_data,
   input  logic               core_is_legal,
   input  logic               core_change_row,
   input  logic               core_valid,
   input  logic               core_done_cao,
   // results
   output logic signed [19:0] res_data,
   output logic               res_valid,
   output logic               res_row_end,
   output logic               res_illegal,
   output logic               busy,
   output logic               done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_A  = 3'd1;
   localparam logic [2:0] S_LOAD_B  = 3'd2;
   localparam logic [2:0] S_FLUSH   = 3'd3;
   localparam logic [2:0] S_COMPUTE = 3'd4;

   logic [2:0]         r_state;
   logic [2:0]         w_state_next;
   logic               r_armed;

   logic [1:0]         r_a_rows;
   logic [1:0]         r_a_cols;
   logic [1:0]         r_b_rows;
   logic [1:0]         r_b_cols;
   logic [1:0]         r_row;
   logic [1:0]         r_col;
   logic [1:0]         w_row_next;
   logic [1:0]         w_col_next;
   logic [1:0]         w_row_lim;
   logic [1:0]         w_col_lim;

   logic [7:0]         r_in_data;
   logic               r_next_matrix;
   logic               r_can_read;
   logic               r_can_cao;
   logic [1:0]         r_row_counter;
   logic [1:0]         r_col_counter;
   logic signed [19:0] r_res_data;
   logic               r_res_valid;
   logic               r_res_row_end;
   logic               r_res_illegal;
   logic               r_busy;
   logic               r_done;

   logic               w_loading;
   logic               w_beat;
   logic               w_last_col;
   logic               w_last_elem;
   logic               w_start_ok;
   logic               w_dim_bad;
   logic               w_core_take;
   logic               w_cao_done;

   assign w_loading   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   assign w_beat      = w_loading && host_valid;
   assign w_row_lim   = (r_state == S_LOAD_B) ? r_b_rows : r_a_rows;
   assign w_col_lim   = (r_state == S_LOAD_B) ? r_b_cols : r_a_cols;
   assign w_last_col  = (r_col == w_col_lim);
   assign w_last_elem = w_last_col && (r_row == w_row_lim);
   // r_armed keeps the first edge after reset release from accepting a start
   assign w_start_ok  = (r_state == S_IDLE) && start && r_armed;
   assign w_core_take = (r_state == S_COMPUTE) && core_valid;
   // The core may only finish once it has actually been told to compute
   assign w_cao_done  = (r_state == S_COMPUTE) && r_can_cao && core_done_cao;

`ifdef DIM_CHECK_EN
   assign w_dim_bad = (a_cols != b_rows);
`else
   assign w_dim_bad = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start_ok && !w_dim_bad) w_state_next = S_LOAD_A;
         S_LOAD_A:  if (w_beat && w_last_elem)    w_state_next = S_LOAD_B;
         S_LOAD_B:  if (w_beat && w_last_elem)    w_state_next = S_FLUSH;
         S_FLUSH:                                 w_state_next = S_COMPUTE;
         S_COMPUTE: if (w_cao_done)               w_state_next = S_IDLE;
         default:                                 w_state_next = S_IDLE;
      endcase
   end

   // Row-major element index; wraps to 0,0 at the end of each matrix
   always_comb begin
      w_row_next = r_row;
      w_col_next = r_col;
      if (w_start_ok) begin
         w_row_next = 2'd0;
         w_col_next = 2'd0;
      end else if (w_beat) begin
         if (w_last_col) begin
            w_col_next = 2'd0;
            w_row_next = w_last_elem ? 2'd0 : r_row + 2'd1;
         end else begin
            w_col_next = r_col + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_armed       <= 1'b0;
         r_a_rows      <= 2'd0;
         r_a_cols      <= 2'd0;
         r_b_rows      <= 2'd0;
         r_b_cols      <= 2'd0;
         r_row         <= 2'd0;
         r_col         <= 2'd0;
         r_in_data     <= 8'd0;
         r_next_matrix <= 1'b0;
         r_can_read    <= 1'b0;
         r_can_cao     <= 1'b0;
         r_row_counter <= 2'd0;
         r_col_counter <= 2'd0;
         r_res_data    <= 20'sd0;
         r_res_valid   <= 1'b0;
         r_res_row_end <= 1'b0;
         r_res_illegal <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_armed <= 1'b1;
         r_row   <= w_row_next;
         r_col   <= w_col_next;

         if (w_start_ok) begin
            r_a_rows <= a_rows;
            r_a_cols <= a_cols;
            r_b_rows <= b_rows;
            r_b_cols <= b_cols;
         end

         r_can_read <= w_beat;
         if (w_beat) begin
            r_in_data     <= host_data;
            r_next_matrix <= (r_state == S_LOAD_B);
            r_row_counter <= r_row;
            r_col_counter <= r_col;
         end

         // Keyed off the current state so FLUSH leaves one quiet cycle after the last write
         r_can_cao <= (r_state == S_COMPUTE) && !w_cao_done;
         r_busy    <= (w_state_next != S_IDLE);
         r_done    <= w_cao_done || (w_start_ok && w_dim_bad);

         r_res_valid <= w_core_take;
         if (w_core_take) begin
            r_res_data <= core_out_data;
         end
         r_res_row_end <= w_core_take && core_change_row;
         r_res_illegal <= (w_core_take && !core_is_legal) || (w_start_ok && w_dim_bad);
      end
   end

   assign host_ready  = w_loading;
   assign in_data     = r_in_data;
   assign next_matrix = r_next_matrix;
   assign can_read    = r_can_read;
   assign can_cao     = r_can_cao;
   assign row_counter = r_row_counter;
   assign col_counter = r_col_counter;
   assign res_data    = r_res_data;
   assign res_valid   = r_res_valid;
   assign res_row_end = r_res_row_end;
   assign res_illegal = r_res_illegal;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have host ports: start in 1 begin job; a_rows, a_cols, b_rows, b_cols in 2 each, dimension minus one (0..3 = 1..4); host_data in 8 signed element; host_valid in 1; host_ready out 1.
REQ-004 SHALL have core-drive ports, all registered outputs: in_data out 8; next_matrix out 1 (0=A, 1=B); can_read out 1; can_cao out 1; row_counter out 2; col_counter out 2.
REQ-005 SHALL have core-return ports: core_out_data in 20 signed; core_is_legal in 1; core_change_row in 1; core_valid in 1; core_done_cao in 1.
REQ-006 SHALL have result ports, all registered: res_data out 20 signed; res_valid out 1; res_row_end out 1; res_illegal out 1; busy out 1; done out 1 (one-cycle pulse).

Function
REQ-007 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, FLUSH, COMPUTE.
REQ-008 IDLE: on start=1, SHALL sample the four dimensions, clear the counters, and go to LOAD_A; start outside IDLE SHALL be ignored.
REQ-009 host_ready SHALL be 1 exactly in LOAD_A and LOAD_B; a beat is accepted when host_valid and host_ready are both 1 at an edge.
REQ-010 Each accepted beat SHALL drive, for exactly the next cycle, can_read=1, in_data=host_data, row_counter/col_counter = current element index, and next_matrix = 0 in LOAD_A and 1 in LOAD_B; can_read SHALL be 0 in every other cycle.
REQ-011 Element order SHALL be row-major: col increments to its dimension, then wraps to 0 and row increments; host_valid gaps SHALL stall the counters without emitting writes.
REQ-012 The last A beat (a_rows,a_cols) SHALL move the FSM to LOAD_B with counters cleared; the last B beat (b_rows,b_cols) SHALL move it to FLUSH.
REQ-013 FLUSH SHALL last one cycle, so the final write completes before can_cao rises; the FSM then enters COMPUTE.
REQ-014 COMPUTE SHALL hold can_cao=1 until core_done_cao=1 is sampled, then drop can_cao, pulse done=1 for one cycle, and return to IDLE.
REQ-015 Every core_valid=1 cycle SHALL produce res_valid=1 one cycle later, with res_data=core_out_data, res_row_end=core_change_row, and res_illegal=!core_is_legal.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 core_valid outside COMPUTE SHALL be ignored (res_valid remains 0).
REQ-018 done and a coincident final res_valid SHALL both be emitted; neither suppresses the other.

Reset
REQ-019 Asserting rst SHALL immediately return the FSM to IDLE and clear all counters and dimension registers.
REQ-020 Asserting rst SHALL immediately drive every output to 0, including mid-LOAD and mid-COMPUTE.
REQ-021 After rst deasserts, the first start SHALL be accepted no earlier than the second rising edge; the core SHALL share the same rst.

Configuration
REQ-022 With DIM_CHECK_EN defined, a start with a_cols != b_rows SHALL skip loading, pulse done and res_illegal together for one cycle one edge after start, and return to IDLE with no core traffic.
REQ-023 Without DIM_CHECK_EN, mismatched jobs SHALL load normally and the core's illegal result SHALL be forwarded under REQ-015.

Verification
REQ-024 2x2 identity times [[1,2],[3,4]] -> res_data 1,2,3,4 in order; res_row_end=1 on 2 and 4; then done=1.
REQ-025 4x4 A all 127 times 4x4 B all -128 -> 16 results each -65024; res_illegal=0 throughout.
REQ-026 A 2x3, B 2x2, DIM_CHECK_EN defined -> done=1 and res_illegal=1 one edge after start; can_read never 1. Without the macro -> one res_valid with res_illegal=1, then done.
REQ-027 1x1 job, host_valid toggling 1,0,0,1 -> exactly two can_read cycles (next_matrix 0 then 1), and can_cao rises two cycles after the B write; 5*(-3) -> res_data -15.
REQ-028 rst pulsed mid-LOAD_B -> all outputs 0 within the same cycle, busy=0; a new 1x1 job afterwards completes correctly.
